// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S transmitter slice.
package i2s_pkg;

    localparam int SLOT_BITS            = 32;
    localparam int FRAME_BITS           = 64;
    localparam int DEFAULT_SAMPLE_WIDTH = 24;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    typedef logic [DEFAULT_SAMPLE_WIDTH-1:0] sample_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO with occupancy count; DEPTH must be a power of two.
module sample_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                       system_clock,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // NOTE: storage has no reset; only pointers and count define validity.
    always_ff @(posedge system_clock) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge system_clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/i2s_tx.sv
// Philips I2S transmitter: sample FIFO, BCLK/LRCLK generation, mono-to-stereo shifter.
// Optional macro I2S_TX_UNDERRUN_HOLD_EN repeats the last sample on underrun instead of silence.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 24,
    parameter int BCLK_DIV     = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    system_clock,
    input  logic                    rst_n,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    input  logic                    flags_clear,
    output logic                    i2s_bclk,
    output logic                    i2s_lrclk,
    output logic                    i2s_sdata,
    output logic                    underrun,
    output logic                    overflow
);

    localparam int DIV_W  = $clog2(BCLK_DIV);
    localparam int BIT_W  = $clog2(FRAME_BITS);
    localparam int SLOT_W = $clog2(SLOT_BITS);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    state_t                  state;
    state_t                  state_next;
    logic [DIV_W-1:0]        div_cnt;
    logic [BIT_W-1:0]        bit_cnt;
    logic [BIT_W-1:0]        bit_next;
    logic [SAMPLE_WIDTH-1:0] sample_reg;

    logic                    fifo_full;
    logic                    fifo_empty;
    logic [CNT_W-1:0]        fifo_count;
    logic [SAMPLE_WIDTH-1:0] fifo_rdata;

    logic                    push;
    logic                    pop;
    logic                    div_tc;
    logic                    fall_tgl;
    logic                    frame_start;
    logic [SLOT_W-1:0]       slot_k;
    logic [SLOT_BITS-1:0]    slot_word;
    logic [SLOT_BITS-1:0]    slot_shift;
    logic                    sdata_next;

    sample_fifo #(
        .WIDTH (SAMPLE_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .system_clock (system_clock),
        .rst_n        (rst_n),
        .push         (push),
        .pop          (pop),
        .wdata        (sample_in),
        .rdata        (fifo_rdata),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .count        (fifo_count)
    );

    assign sample_ready = ~fifo_full;
    assign push         = sample_valid & sample_ready;

    assign div_tc      = (state == S_RUN) && (div_cnt == DIV_W'(BCLK_DIV - 1));
    assign fall_tgl    = div_tc & i2s_bclk;
    assign bit_next    = bit_cnt + BIT_W'(1);
    assign frame_start = fall_tgl && (bit_next == '0);
    assign pop         = frame_start & ~fifo_empty;
    assign slot_k      = bit_next[SLOT_W-1:0];

    // Sample sits at slot bits 1..SAMPLE_WIDTH; shifting by k brings bit k to the MSB.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        slot_word  = SLOT_BITS'(sample_reg) << (SLOT_BITS - 1 - SAMPLE_WIDTH);
        slot_shift = slot_word << slot_k;
        sdata_next = slot_shift[SLOT_BITS-1];
    end

    always_comb begin
        state_next = state;
        if ((state == S_IDLE) && (fifo_count != '0)) begin
            state_next = S_RUN;
        end
    end

    always_ff @(posedge system_clock or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            i2s_bclk   <= 1'b0;
            i2s_lrclk  <= 1'b0;
            i2s_sdata  <= 1'b0;
            sample_reg <= '0;
        end else begin
            state <= state_next;
            if (state == S_IDLE) begin
                // Preload so the first falling toggle wraps into bit 0 and starts a frame.
                if (state_next == S_RUN) begin
                    bit_cnt <= '1;
                end
            end else begin
                if (div_tc) begin
                    div_cnt  <= '0;
                    i2s_bclk <= ~i2s_bclk;
                end else begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end
                if (fall_tgl) begin
                    bit_cnt   <= bit_next;
                    i2s_lrclk <= bit_next[BIT_W-1];
                    i2s_sdata <= sdata_next;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
                    if (pop) begin
                        sample_reg <= fifo_rdata;
                    end
`else
                    if (pop) begin
                        sample_reg <= fifo_rdata;
                    end else if (frame_start) begin
                        sample_reg <= '0;
                    end
`endif
                end
            end
        end
    end

    // Sticky flags: a set event in the same cycle beats flags_clear.
    always_ff @(posedge system_clock or negedge rst_n) begin
        if (!rst_n) begin
            underrun <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (frame_start && fifo_empty) begin
                underrun <= 1'b1;
            end else if (flags_clear) begin
                underrun <= 1'b0;
            end
            if (sample_valid && !sample_ready) begin
                overflow <= 1'b1;
            end else if (flags_clear) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: decodes SDATA on BCLK rising edges and compares frames to expected samples.
module tb_i2s_tx;
    import i2s_pkg::*;

    localparam int SW        = 24;
    localparam int BD        = 4;
    localparam int FD        = 4;
    localparam int FRAME_CYC = 2 * BD * FRAME_BITS;

    logic          system_clock = 1'b0;
    logic          rst_n        = 1'b0;
    logic [SW-1:0] sample_in    = '0;
    logic          sample_valid = 1'b0;
    logic          flags_clear  = 1'b0;
    logic          sample_ready;
    logic          i2s_bclk;
    logic          i2s_lrclk;
    logic          i2s_sdata;
    logic          underrun;
    logic          overflow;

    int n_checks = 0;
    int n_errors = 0;

    i2s_tx #(
        .SAMPLE_WIDTH (SW),
        .BCLK_DIV     (BD),
        .FIFO_DEPTH   (FD)
    ) dut (
        .system_clock (system_clock),
        .rst_n        (rst_n),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .flags_clear  (flags_clear),
        .i2s_bclk     (i2s_bclk),
        .i2s_lrclk    (i2s_lrclk),
        .i2s_sdata    (i2s_sdata),
        .underrun     (underrun),
        .overflow     (overflow)
    );

    always #5 system_clock = ~system_clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Receiver model: the first BCLK rise after start-up precedes frame bit 0;
    // after that, rise n carries frame bit (n-1) mod 64, left slot first.
    int unsigned edge_cnt = 0;
    int          dec_bit;
    int          lr_errs  = 0;
    logic [31:0] slot_bits;
    logic [31:0] slot_q[$];

    always @(posedge i2s_bclk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt = 0;
            slot_q.delete();
        end else begin
            if (edge_cnt > 0) begin
                dec_bit = int'((edge_cnt - 1) % FRAME_BITS);
                slot_bits[SLOT_BITS - 1 - (dec_bit % SLOT_BITS)] = i2s_sdata;
                if (i2s_lrclk !== (dec_bit >= SLOT_BITS)) lr_errs++;
                if ((dec_bit % SLOT_BITS) == SLOT_BITS - 1) slot_q.push_back(slot_bits);
            end
            edge_cnt++;
        end
    end

    task automatic push(input logic [SW-1:0] s);
        sample_in    = s;
        sample_valid = 1'b1;
        @(negedge system_clock);
        sample_valid = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        check({tag, "_bclk"},     i2s_bclk,     0);
        check({tag, "_lrclk"},    i2s_lrclk,    0);
        check({tag, "_sdata"},    i2s_sdata,    0);
        check({tag, "_ready"},    sample_ready, 1);
        check({tag, "_underrun"}, underrun,     0);
        check({tag, "_overflow"}, overflow,     0);
        repeat (3) @(negedge system_clock);
        rst_n = 1'b1;
        @(negedge system_clock);
    endtask

    task automatic idle_check(input string tag);
        int highs = 0;
        repeat (1000) begin
            @(negedge system_clock);
            if (i2s_bclk) highs++;
        end
        check(tag, highs, 0);
    endtask

    // Wait for one decoded frame and compare both slots and the zero padding.
    task automatic next_frame(input string tag, input logic [SW-1:0] exp);
        logic [31:0] l;
        logic [31:0] r;
        int waited = 0;
        while (slot_q.size() < 2 && waited < 3 * FRAME_CYC) begin
            @(negedge system_clock);
            waited++;
        end
        check({tag, "_wait"}, slot_q.size() >= 2, 1);
        if (slot_q.size() >= 2) begin
            l = slot_q.pop_front();
            r = slot_q.pop_front();
            check({tag, "_left"},  l[SLOT_BITS-2 -: SW], exp);
            check({tag, "_right"}, r[SLOT_BITS-2 -: SW], exp);
            check({tag, "_pad"},   {l[31], l[6:0], r[31], r[6:0]}, 0);
        end
    endtask

    task automatic wait_bclk_high(input string tag, input int min_slots);
        int waited = 0;
        while (!(i2s_bclk && slot_q.size() >= min_slots) && waited < 2 * FRAME_CYC) begin
            @(negedge system_clock);
            waited++;
        end
        check({tag, "_bclk_high"}, i2s_bclk, 1);
    endtask

    initial begin
        sample_t rnd[10];
        sample_t ovf[5];
        sample_t exp_hold;

        @(negedge system_clock);
        do_reset("por");
        idle_check("idle_no_push");

        // Single sample, then reset while BCLK is high.
        push(24'hA5C3F0);
        next_frame("single", 24'hA5C3F0);
        wait_bclk_high("pre_midrun", 0);
        do_reset("midrun");

        // Underrun: one sample, then nothing.
        push(24'h123456);
        next_frame("ur_f1", 24'h123456);
        check("ur_flag_before", underrun, 0);
`ifdef I2S_TX_UNDERRUN_HOLD_EN
        exp_hold = 24'h123456;
`else
        exp_hold = '0;
`endif
        next_frame("ur_f2", exp_hold);
        check("ur_flag", underrun, 1);
        flags_clear = 1'b1;
        @(negedge system_clock);
        flags_clear = 1'b0;
        check("ur_cleared", underrun, 0);

        // Ramp stream: keep the FIFO topped up one sample per frame.
        do_reset("pre_ramp");
        for (int i = 1; i <= 4; i++) push(SW'(i));
        for (int i = 1; i <= 8; i++) begin
            next_frame($sformatf("ramp%0d", i), SW'(i));
            if (i <= 4) push(SW'(i + 4));
        end
        check("ramp_underrun", underrun, 0);
        check("ramp_overflow", overflow, 0);

        // Random stream, interrupted by reset with samples still queued.
        do_reset("pre_rand");
        for (int i = 0; i < 10; i++) rnd[i] = SW'($urandom);
        for (int i = 0; i < 4; i++) push(rnd[i]);
        for (int i = 0; i < 6; i++) begin
            next_frame($sformatf("rand%0d", i), rnd[i]);
            push(rnd[i + 4]);
        end
        check("rand_underrun", underrun, 0);
        wait_bclk_high("pre_flush", 1);
        do_reset("flush");
        idle_check("idle_after_flush");

        // Overflow and flags_clear priority.
        for (int i = 0; i < 5; i++) ovf[i] = SW'($urandom);
        for (int i = 0; i < 5; i++) push(ovf[i]);
        check("ovf_ready", sample_ready, 0);
        check("ovf_flag", overflow, 1);
        flags_clear = 1'b1;
        @(negedge system_clock);
        flags_clear = 1'b0;
        check("ovf_cleared", overflow, 0);
        flags_clear  = 1'b1;
        sample_in    = SW'($urandom);
        sample_valid = 1'b1;
        @(negedge system_clock);
        flags_clear  = 1'b0;
        sample_valid = 1'b0;
        check("ovf_set_wins", overflow, 1);
        for (int i = 0; i < 4; i++) next_frame($sformatf("ovf%0d", i), ovf[i]);

        check("lrclk_framing", lr_errs, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
